// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite master running an external command stream, one transaction outstanding; VALIDs rise the cycle after accept, results register the cycle after the response.
// CMD_READY only in IDLE, each VALID holds until its own READY, and HALT blocks further commands until reset.
module axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES   = 1024,
    parameter int C_STOP_ON_ERROR    = 1
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,
    input  logic                              CMD_VALID,
    output logic                              CMD_READY,
    input  logic                              CMD_WRITE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_DATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   CMD_STRB,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_MASK,
    input  logic                              CMD_LAST,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     RD_DATA,
    output logic                              RD_DATA_VALID,
    output logic [1:0]                        ERR_CODE,
    output logic [7:0]                        ERR_COUNT,
    output logic                              DONE
);

    localparam int AW  = C_M_AXI_ADDR_WIDTH;
    localparam int DW  = C_M_AXI_DATA_WIDTH;
    localparam int SW  = DW / 8;
    localparam int WDW = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LIMIT  = WDW'(C_TIMEOUT_CYCLES);
    localparam logic           STOP_ON_ERR = (C_STOP_ON_ERROR != 0);

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_RESP, HALT
    } state_t;

    state_t state_q, state_nxt;

    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  data_q;
    logic [DW-1:0]  mask_q;
    logic [SW-1:0]  strb_q;
    logic           last_q;
    logic           aw_vld_q, w_vld_q, ar_vld_q;
    logic           bready_q, rready_q, cmd_rdy_q;
    logic [DW-1:0]  rd_data_q;
    logic           rd_vld_q;
    logic [1:0]     err_code_q;
    logic [7:0]     err_cnt_q;
    logic           done_q;
    logic [WDW-1:0] wdog_q;

    logic           cmd_acc;
    logic           aw_hs, w_hs, ar_hs, b_hs, r_hs, resp_hs;
    logic           rsp_err, cmp_err, txn_err, halt_on_err;
    logic           active, timeout, any_err;
    logic [WDW-1:0] wdog_inc, wdog_nxt;
    logic           aw_vld_nxt, w_vld_nxt, ar_vld_nxt, done_nxt;
    logic [1:0]     err_code_nxt;
    logic [7:0]     err_cnt_nxt;
    logic           unused_resp_bits;

    // Only bit 1 of a response distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    assign unused_resp_bits = &{1'b0, M_AXI_BRESP[0], M_AXI_RRESP[0]};

    always_comb begin
        state_nxt    = state_q;
        aw_vld_nxt   = aw_vld_q;
        w_vld_nxt    = w_vld_q;
        ar_vld_nxt   = ar_vld_q;
        done_nxt     = done_q;
        err_code_nxt = err_code_q;
        err_cnt_nxt  = err_cnt_q;
        wdog_nxt     = wdog_q;

        cmd_acc     = CMD_VALID & cmd_rdy_q;
        aw_hs       = aw_vld_q & M_AXI_AWREADY;
        w_hs        = w_vld_q & M_AXI_WREADY;
        ar_hs       = ar_vld_q & M_AXI_ARREADY;
        b_hs        = (state_q == WR_RESP) & M_AXI_BVALID & bready_q;
        r_hs        = (state_q == RD_RESP) & M_AXI_RVALID & rready_q;
        resp_hs     = b_hs | r_hs;
        rsp_err     = (b_hs & M_AXI_BRESP[1]) | (r_hs & M_AXI_RRESP[1]);
        cmp_err     = r_hs & (|((M_AXI_RDATA ^ data_q) & mask_q));
        txn_err     = rsp_err | cmp_err;
        halt_on_err = txn_err & STOP_ON_ERR;

        active   = (state_q == WR_ISSUE) | (state_q == WR_RESP) |
                   (state_q == RD_ISSUE) | (state_q == RD_RESP);
        wdog_inc = wdog_q + WDW'(1);
        // A response landing on the final watchdog cycle still completes the transaction.
        timeout  = active & (wdog_inc == WDOG_LIMIT) & ~resp_hs;
        any_err  = txn_err | timeout;

        if (cmd_acc) begin
            wdog_nxt = '0;
        end else if (active) begin
            wdog_nxt = wdog_inc;
        end

        if (cmd_acc & CMD_WRITE) begin
            aw_vld_nxt = 1'b1;
            w_vld_nxt  = 1'b1;
        end else begin
            if (aw_hs) aw_vld_nxt = 1'b0;
            if (w_hs)  w_vld_nxt  = 1'b0;
        end
        if (cmd_acc & ~CMD_WRITE) begin
            ar_vld_nxt = 1'b1;
        end else if (ar_hs) begin
            ar_vld_nxt = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_acc) state_nxt = CMD_WRITE ? WR_ISSUE : RD_ISSUE;
            end
            WR_ISSUE: begin
                if (timeout) begin
                    state_nxt = HALT;
                end else if ((~aw_vld_q | aw_hs) & (~w_vld_q | w_hs)) begin
                    state_nxt = WR_RESP;
                end
            end
            RD_ISSUE: begin
                if (timeout) begin
                    state_nxt = HALT;
                end else if (ar_hs) begin
                    state_nxt = RD_RESP;
                end
            end
            WR_RESP, RD_RESP: begin
                if (resp_hs) begin
                    state_nxt = halt_on_err ? HALT : IDLE;
                end else if (timeout) begin
                    state_nxt = HALT;
                end
            end
            default: state_nxt = HALT;
        endcase

        if (any_err && (err_code_q == 2'd0)) begin
            err_code_nxt = rsp_err ? 2'd1 : (cmp_err ? 2'd2 : 2'd3);
        end
        if (any_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_nxt = err_cnt_q + 8'd1;
        end

        if (cmd_acc) begin
            done_nxt = 1'b0;
        end else if (resp_hs & last_q & ~halt_on_err) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            strb_q     <= '0;
            last_q     <= 1'b0;
            aw_vld_q   <= 1'b0;
            w_vld_q    <= 1'b0;
            ar_vld_q   <= 1'b0;
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            cmd_rdy_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_vld_q   <= 1'b0;
            err_code_q <= 2'd0;
            err_cnt_q  <= 8'd0;
            done_q     <= 1'b0;
            wdog_q     <= '0;
        end else begin
            if (cmd_acc) begin
                addr_q <= CMD_ADDR;
                data_q <= CMD_DATA;
                mask_q <= CMD_MASK;
                strb_q <= CMD_STRB;
                last_q <= CMD_LAST;
            end
            aw_vld_q   <= aw_vld_nxt;
            w_vld_q    <= w_vld_nxt;
            ar_vld_q   <= ar_vld_nxt;
            bready_q   <= 1'b1;
            rready_q   <= 1'b1;
            cmd_rdy_q  <= (state_nxt == IDLE);
            if (r_hs) rd_data_q <= M_AXI_RDATA;
            rd_vld_q   <= r_hs;
            err_code_q <= err_code_nxt;
            err_cnt_q  <= err_cnt_nxt;
            done_q     <= done_nxt;
            wdog_q     <= wdog_nxt;
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = aw_vld_q;
    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = strb_q;
    assign M_AXI_WVALID  = w_vld_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = ar_vld_q;
    assign M_AXI_RREADY  = rready_q;
    assign CMD_READY     = cmd_rdy_q;
    assign RD_DATA       = rd_data_q;
    assign RD_DATA_VALID = rd_vld_q;
    assign ERR_CODE      = err_code_q;
    assign ERR_COUNT     = err_cnt_q;
    assign DONE          = done_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench: two masters (continue-on-error and stop-on-error) share one command stream and slave model.
module tb_axi_lite_cmd_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          awready, wready, arready, bvalid, rvalid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;
    logic          cmd_valid, cmd_write, cmd_last;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data, cmd_mask;
    logic [SW-1:0] cmd_strb;

    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready, cmd_ready, rd_vld, done;
    logic [DW-1:0] wdata, rd_data;
    logic [SW-1:0] wstrb;
    logic [1:0]    err_code;
    logic [7:0]    err_count;

    logic [AW-1:0] unused_awaddr, unused_araddr;
    logic [2:0]    unused_awprot, unused_arprot;
    logic          unused_awvalid, unused_wvalid, unused_bready, unused_arvalid, unused_rready, unused_rd_vld;
    logic [DW-1:0] unused_wdata, unused_rd_data;
    logic [SW-1:0] unused_wstrb;
    logic          s_cmd_ready, s_done;
    logic [1:0]    s_err_code;
    logic [7:0]    s_err_count;

    axi_lite_cmd_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
                          .C_TIMEOUT_CYCLES(TMO), .C_STOP_ON_ERROR(0)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write), .CMD_ADDR(cmd_addr),
        .CMD_DATA(cmd_data), .CMD_STRB(cmd_strb), .CMD_MASK(cmd_mask), .CMD_LAST(cmd_last),
        .RD_DATA(rd_data), .RD_DATA_VALID(rd_vld), .ERR_CODE(err_code), .ERR_COUNT(err_count), .DONE(done)
    );

    axi_lite_cmd_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
                          .C_TIMEOUT_CYCLES(TMO), .C_STOP_ON_ERROR(1)) dut_stop (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .M_AXI_AWADDR(unused_awaddr), .M_AXI_AWPROT(unused_awprot), .M_AXI_AWVALID(unused_awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(unused_wdata), .M_AXI_WSTRB(unused_wstrb), .M_AXI_WVALID(unused_wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(unused_bready),
        .M_AXI_ARADDR(unused_araddr), .M_AXI_ARPROT(unused_arprot), .M_AXI_ARVALID(unused_arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(unused_rready),
        .CMD_VALID(cmd_valid), .CMD_READY(s_cmd_ready), .CMD_WRITE(cmd_write), .CMD_ADDR(cmd_addr),
        .CMD_DATA(cmd_data), .CMD_STRB(cmd_strb), .CMD_MASK(cmd_mask), .CMD_LAST(cmd_last),
        .RD_DATA(unused_rd_data), .RD_DATA_VALID(unused_rd_vld), .ERR_CODE(s_err_code),
        .ERR_COUNT(s_err_count), .DONE(s_done)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    // Reference state: m0_* for the continue-on-error master, m1_* for the stop-on-error one.
    logic [1:0] m0_code, m1_code;
    int         m0_cnt, m1_cnt;
    logic       m0_done, m1_done, m1_halt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m0_code = 2'd0; m1_code = 2'd0;
        m0_cnt  = 0;    m1_cnt  = 0;
        m0_done = 1'b0; m1_done = 1'b0; m1_halt = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
        chk({tag, "_valids"}, 64'({awvalid, wvalid, arvalid}), 64'(0));
        chk({tag, "_readies"}, 64'({bready, rready}), 64'(0));
        chk({tag, "_rd_vld"}, 64'(rd_vld), 64'(0));
        chk({tag, "_rd_data"}, 64'(rd_data), 64'(0));
        chk({tag, "_addr_data"}, 64'({awaddr, wdata}), 64'(0));
        chk({tag, "_err"}, 64'({err_code, err_count, done}), 64'(0));
        chk({tag, "_stop_err"}, 64'({s_cmd_ready, s_err_code, s_err_count, s_done}), 64'(0));
    endtask

    task automatic reset_all();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_last = 1'b0;
        cmd_addr = '0; cmd_data = '0; cmd_mask = '0; cmd_strb = '0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00; rdata = '0;
        @(posedge clk); #1;
        chk_reset_vals("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_exit_ready", 64'({cmd_ready, bready, rready}), 64'(3'b111));
        model_reset();
    endtask

    task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input logic [DW-1:0] mask, input logic last,
                          input int aw_dly, input int w_dly, input int rsp_dly,
                          input logic [1:0] resp, input logic [DW-1:0] rdat);
        int   c;
        logic aw_pend, w_pend, ar_pend, rsp_e, cmp_e;
        c = 0;
        while (cmd_ready !== 1'b1 && c < 30) begin
            @(posedge clk); #1;
            c++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        if (cmd_ready !== 1'b1) return;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_data = data;
        cmd_strb = strb; cmd_mask = mask; cmd_last = last;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("accept_ready_drop", 64'(cmd_ready), 64'(0));
        chk("accept_done_clr", 64'(done), 64'(0));
        chk("accept_rdv_low", 64'(rd_vld), 64'(0));
        if (wr) begin
            chk("awaddr", 64'(awaddr), 64'(addr));
            chk("wdata", 64'(wdata), 64'(data));
            chk("wstrb", 64'(wstrb), 64'(strb));
            chk("awprot", 64'(awprot), 64'(0));
        end else begin
            chk("araddr", 64'(araddr), 64'(addr));
            chk("arprot", 64'(arprot), 64'(0));
        end
        aw_pend = wr; w_pend = wr; ar_pend = !wr;
        c = 0;
        while ((aw_pend || w_pend || ar_pend) && c < 40) begin
            chk("awvalid", 64'(awvalid), 64'(aw_pend));
            chk("wvalid", 64'(wvalid), 64'(w_pend));
            chk("arvalid", 64'(arvalid), 64'(ar_pend));
            awready = aw_pend && c >= aw_dly;
            wready  = w_pend && c >= w_dly;
            arready = ar_pend && c >= aw_dly;
            @(posedge clk); #1;
            if (awready) aw_pend = 1'b0;
            if (wready)  w_pend  = 1'b0;
            if (arready) ar_pend = 1'b0;
            awready = 1'b0; wready = 1'b0; arready = 1'b0;
            c++;
        end
        chk("valids_dropped", 64'({awvalid, wvalid, arvalid}), 64'(0));
        for (int d = 0; d < rsp_dly; d++) begin
            chk("busy_no_ready", 64'(cmd_ready), 64'(0));
            @(posedge clk); #1;
        end
        if (wr) begin
            bvalid = 1'b1; bresp = resp;
            chk("bready", 64'(bready), 64'(1));
        end else begin
            rvalid = 1'b1; rresp = resp; rdata = rdat;
            chk("rready", 64'(rready), 64'(1));
        end
        @(posedge clk); #1;
        bvalid = 1'b0; rvalid = 1'b0;

        rsp_e = resp[1];
        cmp_e = !wr && (((rdat ^ data) & mask) != '0);
        if (rsp_e || cmp_e) begin
            if (m0_code == 2'd0) m0_code = rsp_e ? 2'd1 : 2'd2;
            if (m0_cnt < 255) m0_cnt++;
        end
        m0_done = last;
        if (!m1_halt) begin
            if (rsp_e || cmp_e) begin
                m1_halt = 1'b1;
                m1_code = rsp_e ? 2'd1 : 2'd2;
                m1_cnt  = 1;
                m1_done = 1'b0;
            end else begin
                m1_done = last;
            end
        end

        chk("cmd_ready_back", 64'(cmd_ready), 64'(1));
        chk("err_code", 64'(err_code), 64'(m0_code));
        chk("err_count", 64'(err_count), 64'(m0_cnt));
        chk("done", 64'(done), 64'(m0_done));
        if (!wr) begin
            chk("rd_vld", 64'(rd_vld), 64'(1));
            chk("rd_data", 64'(rd_data), 64'(rdat));
        end else begin
            chk("rd_vld_on_write", 64'(rd_vld), 64'(0));
        end
        chk("stop_cmd_ready", 64'(s_cmd_ready), 64'(!m1_halt));
        chk("stop_err_code", 64'(s_err_code), 64'(m1_code));
        chk("stop_err_count", 64'(s_err_count), 64'(m1_cnt));
        chk("stop_done", 64'(s_done), 64'(m1_done));
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            logic          wr;
            logic [DW-1:0] d, m, rd;
            logic [1:0]    rs;
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            m  = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            rd = ($urandom_range(0, 1) == 1) ? (d ^ ($urandom & ~m)) : $urandom;
            rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            do_cmd(wr, $urandom, d, 4'($urandom), m, (i == n - 1),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rs, rd);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset_all();

        // Basic write, and write with AW accepted well before W.
        do_cmd(1'b1, 32'h8800_0000, 32'hA5A5_A5A5, 4'hF, '0, 1'b0, 0, 0, 0, 2'b00, '0);
        chk("t1_err_code", 64'(err_code), 64'(0));
        do_cmd(1'b1, 32'h8800_0004, 32'h0BAD_F00D, 4'h3, '0, 1'b0, 0, 3, 1, 2'b00, '0);

        // Masked compare: upper half matches, then differs.
        do_cmd(1'b0, 32'h8800_0008, 32'h1234_5678, '0, 32'hFFFF_0000, 1'b0, 1, 0, 2, 2'b00, 32'h1234_ABCD);
        chk("t3_no_err", 64'(err_code), 64'(0));
        do_cmd(1'b0, 32'h8800_0008, 32'h1234_5678, '0, 32'hFFFF_0000, 1'b1, 0, 0, 0, 2'b00, 32'h1235_ABCD);
        chk("t3_mismatch_code", 64'(err_code), 64'(2));
        chk("t3_stop_halted", 64'(s_cmd_ready), 64'(0));

        rand_run(30);

        // Saturating error count with continue-on-error.
        reset_all();
        for (int i = 0; i < 300; i++) begin
            do_cmd(1'b1, 32'(i * 4), $urandom, 4'hF, '0, (i == 299), 0, 0, 0, 2'b10, '0);
        end
        chk("t4_count_sat", 64'(err_count), 64'(255));
        chk("t4_code", 64'(err_code), 64'(1));
        chk("t4_done", 64'(done), 64'(1));

        // Watchdog with ARREADY held low.
        reset_all();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0010; cmd_mask = '0; cmd_last = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk); #1;
            chk("t5_arvalid", 64'(arvalid), 64'(1));
            chk("t5_err_code", 64'(err_code), 64'((k == TMO) ? 3 : 0));
        end
        chk("t5_err_count", 64'(err_count), 64'(1));
        chk("t5_stop_code", 64'(s_err_code), 64'(3));
        cmd_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_halt_ready", 64'(cmd_ready), 64'(0));
        chk("t5_halt_arvalid", 64'(arvalid), 64'(1));
        chk("t5_halt_done", 64'(done), 64'(0));
        cmd_valid = 1'b0;

        // Reset while a write response is pending, with stray responses afterwards.
        reset_all();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0100; cmd_data = 32'hCAFE_0001;
        cmd_strb = 4'hF; cmd_last = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
        @(posedge clk); #1;
        awready = 1'b0; wready = 1'b0;
        chk("t6_issued", 64'({awvalid, wvalid}), 64'(0));
        rst = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        @(posedge clk); #1;
        chk_reset_vals("t6_rst");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_ready", 64'({cmd_ready, bready}), 64'(2'b11));
        @(posedge clk); #1;
        bvalid = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rvalid = 1'b0;
        chk("t6_stray_ignored", 64'({err_code, err_count, rd_vld}), 64'(0));
        model_reset();

        // Response error and compare mismatch together: response error is reported.
        do_cmd(1'b0, 32'h0000_0200, 32'h0000_00FF, '0, 32'h0000_00FF, 1'b0, 0, 0, 1, 2'b11, 32'h0000_0000);
        chk("prio_code", 64'(err_code), 64'(1));

        rand_run(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
